ibex_cheri_mem_exc_tracker: RTL and testbench

//  Downstream of the CHERI memory checker. It queues the per-request CHERI exception vector at

---
 rtl/ibex_cheri_mem_exc_tracker_pkg.sv | 42 ++++
 rtl/ibex_cheri_mem_exc_tracker_if.sv | 30 +++
 rtl/ibex_cheri_exc_prio_enc.sv | 19 +
 rtl/ibex_cheri_mem_exc_tracker.sv | 111 +++++++++++
 tb/tb_ibex_cheri_mem_exc_tracker.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_cheri_mem_exc_tracker_pkg.sv
// Shared CHERI exception encodings: violation bit indices, prioritised cause codes and the
// priority function used by both the LSU response path and the IF stage.
package ibex_cheri_mem_exc_tracker_pkg;

  localparam int CheriExcWidth = 6;

  localparam int TAG_VIOLATION            = 0;
  localparam int SEAL_VIOLATION           = 1;
  localparam int PERMIT_EXECUTE_VIOLATION = 2;
  localparam int PERMIT_LOAD_VIOLATION    = 3;
  localparam int PERMIT_STORE_VIOLATION   = 4;
  localparam int LENGTH_VIOLATION         = 5;

  typedef logic [CheriExcWidth-1:0] cheri_exc_t;

  typedef enum logic [4:0] {
    CHERI_CAUSE_NONE           = 5'h00,
    CHERI_CAUSE_LENGTH         = 5'h01,
    CHERI_CAUSE_TAG            = 5'h02,
    CHERI_CAUSE_SEAL           = 5'h03,
    CHERI_CAUSE_PERMIT_EXECUTE = 5'h11,
    CHERI_CAUSE_PERMIT_LOAD    = 5'h12,
    CHERI_CAUSE_PERMIT_STORE   = 5'h13
  } cheri_cause_e;

  // Per-request payload held while the request is in flight.
  typedef struct packed {
    logic       upper;
    cheri_exc_t exc_vec;
  } exc_entry_t;

  function automatic cheri_cause_e cheri_exc_prio(cheri_exc_t vec);
    if      (vec[TAG_VIOLATION])            return CHERI_CAUSE_TAG;
    else if (vec[SEAL_VIOLATION])           return CHERI_CAUSE_SEAL;
    else if (vec[PERMIT_EXECUTE_VIOLATION]) return CHERI_CAUSE_PERMIT_EXECUTE;
    else if (vec[PERMIT_LOAD_VIOLATION])    return CHERI_CAUSE_PERMIT_LOAD;
    else if (vec[PERMIT_STORE_VIOLATION])   return CHERI_CAUSE_PERMIT_STORE;
    else if (vec[LENGTH_VIOLATION])         return CHERI_CAUSE_LENGTH;
    else                                    return CHERI_CAUSE_NONE;
  endfunction

endpackage

// File: rtl/ibex_cheri_mem_exc_tracker_if.sv
// Request/response bundle between the LSU (or IF stage) and the CHERI exception tracker.
interface ibex_cheri_mem_exc_tracker_if;
  import ibex_cheri_mem_exc_tracker_pkg::*;

  logic         data_req_i;
  logic         data_gnt_i;
  logic         data_rvalid_i;
  cheri_exc_t   exc_vec_i;
  logic         instr_upper_exc_i;
  logic         flush_i;

  logic         req_allowed_o;
  logic         rsp_exc_valid_o;
  cheri_exc_t   rsp_exc_vec_o;
  cheri_cause_e rsp_cause_o;
  logic         rsp_upper_exc_o;
  logic         rsp_discard_o;

  modport master (
    output data_req_i, data_gnt_i, data_rvalid_i, exc_vec_i, instr_upper_exc_i, flush_i,
    input  req_allowed_o, rsp_exc_valid_o, rsp_exc_vec_o, rsp_cause_o, rsp_upper_exc_o,
           rsp_discard_o
  );

  modport slave (
    input  data_req_i, data_gnt_i, data_rvalid_i, exc_vec_i, instr_upper_exc_i, flush_i,
    output req_allowed_o, rsp_exc_valid_o, rsp_exc_vec_o, rsp_cause_o, rsp_upper_exc_o,
           rsp_discard_o
  );
endinterface

// File: rtl/ibex_cheri_exc_prio_enc.sv
// Combinational CHERI cause encoder; the instruction upper-half bit folds into LENGTH.
module ibex_cheri_exc_prio_enc
  import ibex_cheri_mem_exc_tracker_pkg::*;
(
  input  cheri_exc_t   exc_vec_i,
  input  logic         upper_exc_i,
  output cheri_cause_e cause_o
);

  cheri_exc_t merged_vec;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    merged_vec                   = exc_vec_i;
    merged_vec[LENGTH_VIOLATION] = exc_vec_i[LENGTH_VIOLATION] | upper_exc_i;
    cause_o                      = cheri_exc_prio(merged_vec);
  end

endmodule

// File: rtl/ibex_cheri_mem_exc_tracker.sv
// Queues CHERI exception vectors at grant and reports a prioritised cause on the matching rvalid.
// Optional feature: define IBEX_CHERI_EXC_STATS_EN to add the exc_count_o event counter.
module ibex_cheri_mem_exc_tracker
  import ibex_cheri_mem_exc_tracker_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataMem        = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  ibex_cheri_mem_exc_tracker_if.slave           bus,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
`ifdef IBEX_CHERI_EXC_STATS_EN
  output logic [31:0]                           exc_count_o,
`endif
  output logic                                  proto_err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [CntW-1:0]           count_q;
  logic [PtrW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [MaxOutstanding-1:0] discard_q;
  exc_entry_t                mem_q [MaxOutstanding];
  logic                      proto_err_q;

  logic       push_req, empty, full, do_push, do_pop, overflow, underflow;
  logic       head_discard, show_head;
  exc_entry_t push_entry, head;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MaxOutstanding - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign push_req  = bus.data_req_i & bus.data_gnt_i;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(MaxOutstanding));
  assign do_pop    = bus.data_rvalid_i & ~empty;
  assign do_push   = push_req & (~full | do_pop);
  assign overflow  = push_req & full & ~bus.data_rvalid_i;
  assign underflow = bus.data_rvalid_i & empty;

  assign push_entry.exc_vec = bus.exc_vec_i;
  assign push_entry.upper   = DataMem ? 1'b0 : bus.instr_upper_exc_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      discard_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // Marking idle slots too is harmless: a push always rewrites its slot's discard bit.
      if (bus.flush_i) discard_q <= '1;
      if (do_push) begin
        discard_q[wr_ptr_q] <= 1'b0;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      proto_err_q <= proto_err_q | overflow | underflow;
    end
  end

  // NOTE: payload storage is left unreset; it is only observed behind a live, non-discarded head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head         = mem_q[rd_ptr_q];
  assign head_discard = discard_q[rd_ptr_q] | bus.flush_i;
  assign show_head    = do_pop & ~head_discard;

  assign bus.req_allowed_o   = ~full | bus.data_rvalid_i;
  assign bus.rsp_discard_o   = do_pop & head_discard;
  assign bus.rsp_exc_vec_o   = show_head ? head.exc_vec : '0;
  assign bus.rsp_upper_exc_o = show_head & head.upper;
  assign bus.rsp_exc_valid_o = show_head & ((|head.exc_vec) | head.upper);

  ibex_cheri_exc_prio_enc u_prio_enc (
    .exc_vec_i   (bus.rsp_exc_vec_o),
    .upper_exc_i (bus.rsp_upper_exc_o),
    .cause_o     (bus.rsp_cause_o)
  );

  assign outstanding_o = count_q;
  assign proto_err_o   = proto_err_q;

`ifdef IBEX_CHERI_EXC_STATS_EN
  logic [31:0] exc_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exc_count_q <= '0;
    end else if (bus.rsp_exc_valid_o && (exc_count_q != '1)) begin
      exc_count_q <= exc_count_q + 32'd1;
    end
  end

  assign exc_count_o = exc_count_q;
`endif

endmodule

// File: tb/tb_ibex_cheri_mem_exc_tracker.sv
// Bench for ibex_cheri_mem_exc_tracker: a depth-2 data-side and a depth-3 instr-side instance
// driven by directed and random traffic, checked against a queue-based reference model.
module tb_ibex_cheri_mem_exc_tracker;
  import ibex_cheri_mem_exc_tracker_pkg::*;

  localparam int NI = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ibex_cheri_mem_exc_tracker_if if0 ();
  ibex_cheri_mem_exc_tracker_if if1 ();

  logic       rq [NI], gn [NI], rv [NI], up [NI], fl [NI];
  logic [5:0] vi [NI];

  logic        o_allowed [NI], o_valid [NI], o_up [NI], o_disc [NI], o_perr [NI];
  logic [5:0]  o_vec [NI];
  logic [4:0]  o_cause [NI];
  logic [1:0]  o_out [NI];
  logic [31:0] o_cnt [NI];

  assign if0.data_req_i = rq[0];  assign if1.data_req_i = rq[1];
  assign if0.data_gnt_i = gn[0];  assign if1.data_gnt_i = gn[1];
  assign if0.data_rvalid_i = rv[0];  assign if1.data_rvalid_i = rv[1];
  assign if0.exc_vec_i = vi[0];  assign if1.exc_vec_i = vi[1];
  assign if0.instr_upper_exc_i = up[0];  assign if1.instr_upper_exc_i = up[1];
  assign if0.flush_i = fl[0];  assign if1.flush_i = fl[1];

  assign o_allowed[0] = if0.req_allowed_o;   assign o_allowed[1] = if1.req_allowed_o;
  assign o_valid[0]   = if0.rsp_exc_valid_o; assign o_valid[1]   = if1.rsp_exc_valid_o;
  assign o_vec[0]     = if0.rsp_exc_vec_o;   assign o_vec[1]     = if1.rsp_exc_vec_o;
  assign o_cause[0]   = if0.rsp_cause_o;     assign o_cause[1]   = if1.rsp_cause_o;
  assign o_up[0]      = if0.rsp_upper_exc_o; assign o_up[1]      = if1.rsp_upper_exc_o;
  assign o_disc[0]    = if0.rsp_discard_o;   assign o_disc[1]    = if1.rsp_discard_o;

  ibex_cheri_mem_exc_tracker #(.MaxOutstanding(2), .DataMem(1'b1)) dut0 (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .bus           (if0.slave),
    .outstanding_o (o_out[0]),
`ifdef IBEX_CHERI_EXC_STATS_EN
    .exc_count_o   (o_cnt[0]),
`endif
    .proto_err_o   (o_perr[0])
  );

  ibex_cheri_mem_exc_tracker #(.MaxOutstanding(3), .DataMem(1'b0)) dut1 (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .bus           (if1.slave),
    .outstanding_o (o_out[1]),
`ifdef IBEX_CHERI_EXC_STATS_EN
    .exc_count_o   (o_cnt[1]),
`endif
    .proto_err_o   (o_perr[1])
  );

`ifndef IBEX_CHERI_EXC_STATS_EN
  assign o_cnt[0] = '0;
  assign o_cnt[1] = '0;
`endif

  // Reference model: one queue of tagged entries shared by both instances.
  typedef struct {
    int         inst;
    logic [5:0] vec;
    logic       up;
    logic       disc;
  } ment_t;

  ment_t       mq [$];
  int          depth [NI] = '{2, 3};
  bit          dmem  [NI] = '{1'b1, 1'b0};
  bit          m_perr [NI];
  int unsigned m_cnt [NI];
  bit          m_evalid [NI];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int msize(int k);
    int n = 0;
    foreach (mq[i]) if (mq[i].inst == k) n++;
    return n;
  endfunction

  function automatic int mhead(int k);
    foreach (mq[i]) if (mq[i].inst == k) return i;
    return -1;
  endfunction

  function automatic logic [4:0] exp_cause(logic [5:0] v, logic u);
    int         order [6];
    logic [4:0] code  [6];
    logic [5:0] all_bits;
    order = '{TAG_VIOLATION, SEAL_VIOLATION, PERMIT_EXECUTE_VIOLATION,
              PERMIT_LOAD_VIOLATION, PERMIT_STORE_VIOLATION, LENGTH_VIOLATION};
    code  = '{5'h02, 5'h03, 5'h11, 5'h12, 5'h13, 5'h01};
    all_bits = v;
    if (u) all_bits[LENGTH_VIOLATION] = 1'b1;
    for (int i = 0; i < 6; i++) if (all_bits[order[i]]) return code[i];
    return 5'h00;
  endfunction

  task automatic idle();
    for (int k = 0; k < NI; k++) begin
      rq[k] = 0; gn[k] = 0; rv[k] = 0; up[k] = 0; fl[k] = 0; vi[k] = '0;
    end
  endtask

  // Compare every output of both instances against the model, mid-cycle.
  task automatic sample();
    @(negedge clk_i);
    for (int k = 0; k < NI; k++) begin
      int         sz, h;
      logic [5:0] e_vec;
      logic       e_up, e_disc, e_valid;
      sz = msize(k); h = mhead(k);
      e_vec = '0; e_up = 0; e_disc = 0;
      if (rv[k] && sz > 0) begin
        if (mq[h].disc || fl[k]) e_disc = 1;
        else begin e_vec = mq[h].vec; e_up = mq[h].up; end
      end
      e_valid     = (e_vec != 0) || e_up;
      m_evalid[k] = e_valid;
      check($sformatf("i%0d_allowed", k), 32'(o_allowed[k]), 32'((sz < depth[k]) || rv[k]));
      check($sformatf("i%0d_valid", k),   32'(o_valid[k]),   32'(e_valid));
      check($sformatf("i%0d_vec", k),     32'(o_vec[k]),     32'(e_vec));
      check($sformatf("i%0d_cause", k),   32'(o_cause[k]),   32'(exp_cause(e_vec, e_up)));
      check($sformatf("i%0d_upper", k),   32'(o_up[k]),      32'(e_up));
      check($sformatf("i%0d_discard", k), 32'(o_disc[k]),    32'(e_disc));
      check($sformatf("i%0d_count", k),   32'(o_out[k]),     32'(sz));
      check($sformatf("i%0d_proto", k),   32'(o_perr[k]),    32'(m_perr[k]));
`ifdef IBEX_CHERI_EXC_STATS_EN
      check($sformatf("i%0d_stats", k),   o_cnt[k],          m_cnt[k]);
`endif
    end
  endtask

  // Cross the active edge and apply the same edge to the model.
  task automatic advance();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NI; k++) begin
      int sz, h;
      ment_t e;
      sz = msize(k); h = mhead(k);
      if (m_evalid[k] && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k]++;
      if (fl[k]) foreach (mq[i]) if (mq[i].inst == k) mq[i].disc = 1;
      if (rv[k]) begin
        if (sz > 0) mq.delete(h);
        else m_perr[k] = 1;
      end
      if (rq[k] && gn[k]) begin
        if (sz == depth[k] && !rv[k]) m_perr[k] = 1;
        else begin
          e.inst = k; e.vec = vi[k]; e.up = dmem[k] ? 1'b0 : up[k]; e.disc = 0;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 0;
    mq.delete();
    for (int k = 0; k < NI; k++) begin m_perr[k] = 0; m_cnt[k] = 0; end
    sample();
    @(posedge clk_i);
    #1;
    rst_ni = 1;
  endtask

  task automatic cyc();
    sample();
    advance();
    idle();
  endtask

  initial begin
    idle();
    do_reset();

    // Single load with TAG|LENGTH: TAG wins.
    rq[0] = 1; gn[0] = 1; vi[0] = 6'b10_0001; cyc();
    rv[0] = 1; sample();
    check("t1_valid", 32'(o_valid[0]), 1);
    check("t1_cause", 32'(o_cause[0]), 32'h02);
    check("t1_count", 32'(o_out[0]), 1);
    advance(); idle(); sample();
    check("t1_count_after", 32'(o_out[0]), 0);
    advance();

    // Back-to-back grants: clean, then PERMIT_STORE, popped in order.
    rq[0] = 1; gn[0] = 1; vi[0] = '0; cyc();
    rq[0] = 1; gn[0] = 1; vi[0] = 6'b01_0000; cyc();
    rv[0] = 1; sample(); check("t2_first_valid", 32'(o_valid[0]), 0); advance(); idle();
    rv[0] = 1; sample(); check("t2_second_cause", 32'(o_cause[0]), 32'h13); advance(); idle();

    // Fill to FULL, push+pop keeps count, then overflow.
    rq[0] = 1; gn[0] = 1; cyc();
    rq[0] = 1; gn[0] = 1; cyc();
    sample(); check("t3_full_allowed", 32'(o_allowed[0]), 0); advance();
    rq[0] = 1; gn[0] = 1; rv[0] = 1; cyc();
    sample(); check("t3_pushpop_count", 32'(o_out[0]), 2); advance();
    rq[0] = 1; gn[0] = 1; cyc();
    sample(); check("t3_overflow_err", 32'(o_perr[0]), 1);
    check("t3_overflow_count", 32'(o_out[0]), 2); advance();
    rv[0] = 1; cyc();
    rv[0] = 1; cyc();
    do_reset();

    // Underflow on an empty FIFO.
    rv[0] = 1; sample(); check("t4_under_vec", 32'(o_vec[0]), 0); advance(); idle();
    sample(); check("t4_under_err", 32'(o_perr[0]), 1);
    check("t4_under_count", 32'(o_out[0]), 0); advance();
    do_reset();

    // Flush two SEAL entries while pushing a LENGTH entry.
    rq[1] = 1; gn[1] = 1; vi[1] = 6'b00_0010; cyc();
    rq[1] = 1; gn[1] = 1; vi[1] = 6'b00_0010; cyc();
    rq[1] = 1; gn[1] = 1; vi[1] = 6'b10_0000; fl[1] = 1; cyc();
    for (int i = 0; i < 2; i++) begin
      rv[1] = 1; sample();
      check("t5_discard", 32'(o_disc[1]), 1);
      check("t5_disc_vec", 32'(o_vec[1]), 0);
      advance(); idle();
    end
    rv[1] = 1; sample(); check("t5_length_cause", 32'(o_cause[1]), 32'h01); advance(); idle();
    do_reset();

    // Upper-half bit: reported on the instr side, ignored on the data side.
    for (int k = 0; k < NI; k++) begin rq[k] = 1; gn[k] = 1; up[k] = 1; end
    cyc();
    rv[0] = 1; rv[1] = 1; sample();
    check("t6_instr_cause", 32'(o_cause[1]), 32'h01);
    check("t6_instr_upper", 32'(o_up[1]), 1);
    check("t6_data_upper", 32'(o_up[0]), 0);
    advance(); idle();
    sample();
`ifdef IBEX_CHERI_EXC_STATS_EN
    check("t6_stats", o_cnt[1], 1);
`endif
    advance();

    // Random traffic with occasional flushes, underflows, overflows and mid-run resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 119) == 0) do_reset();
      for (int k = 0; k < NI; k++) begin
        rq[k] = ($urandom_range(0, 3) != 0);
        gn[k] = $urandom_range(0, 1);
        rv[k] = (msize(k) > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
        vi[k] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
        up[k] = ($urandom_range(0, 4) == 0);
        fl[k] = ($urandom_range(0, 14) == 0);
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
